osc_voice: RTL

Parametrised single-voice oscillator for the audio path: a phase accumulator driving four selectable waveforms (sawtooth, triangle, variable-duty pulse, LFSR noise) with per-voice volume shift and hard sync. Sits between the tone lookup (which supplies the phase increment) and the voice mixer; one instance per voice. Waveform, duty and volume changes take effect only at phase wrap, so there are no mid-cycle glitches.

---
 rtl/osc_pkg.sv | 24 ++
 rtl/osc_lfsr.sv | 30 +++
 rtl/osc_voice.sv | 119 +++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared types and constants for the oscillator voice
// Contents: wave_t waveform select, noise LFSR width/taps, shadow-register reset defaults.
package osc_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'd0,
        WAVE_TRI   = 2'd1,
        WAVE_PULSE = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_t;

    // Noise generator: x^15 + x^14 + 1, shifted left with feedback into bit 0.
    localparam int LFSR_W     = 15;
    localparam int LFSR_TAP_A = 14;
    localparam int LFSR_TAP_B = 13;

    localparam logic [2:0] VOL_RESET = 3'd4;

    // Duty reset is half scale for whatever compare width the voice uses.
    function automatic logic [31:0] duty_half(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/osc_lfsr.sv
// rtl/osc_lfsr.sv - 15-bit Fibonacci noise register for the oscillator voice
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset, loads seed
//   advance in  shift one step this cycle
//   seed    in  LFSR_W-bit reset value (must be nonzero)
//   noise   out current register bit 0
module osc_lfsr
    import osc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic              noise
);

    logic [LFSR_W-1:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (advance) begin
            state <= {state[LFSR_W-2:0], state[LFSR_TAP_A] ^ state[LFSR_TAP_B]};
        end
    end

    assign noise = state[0];

endmodule

// File: rtl/osc_voice.sv
// rtl/osc_voice.sv - single oscillator voice: phase accumulator, four waveforms, volume shift, hard sync
// Ports:
//   clk_in    in  system clock
//   rst_in    in  synchronous active-high reset
//   step_in   in  sample strobe, advances phase by incr_in
//   incr_in   in  PHASE_W-bit phase increment
//   wave_in   in  waveform select (wave_t encoding)
//   duty_in   in  DUTY_W-bit pulse high-time threshold
//   vol_in    in  attenuation as arithmetic right shift 0..7
//   sync_in   in  hard sync, phase to zero (counts as a wrap)
//   amp_out   out AMP_W-bit signed sample
//   valid_out out one-cycle pulse with each new amp_out
//   wrap_out  out one-cycle pulse after a phase wrap or sync
module osc_voice
    import osc_pkg::*;
#(
    parameter int                PHASE_W   = 32,
    parameter int                AMP_W     = 8,
    parameter int                DUTY_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    step_in,
    input  logic [PHASE_W-1:0]      incr_in,
    input  logic [1:0]              wave_in,
    input  logic [DUTY_W-1:0]       duty_in,
    input  logic [2:0]              vol_in,
    input  logic                    sync_in,
    output logic signed [AMP_W-1:0] amp_out,
    output logic                    valid_out,
    output logic                    wrap_out
);

    localparam logic [DUTY_W-1:0] DUTY_RESET = DUTY_W'(duty_half(DUTY_W));
    localparam logic [AMP_W-1:0]  AMP_MIN    = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [AMP_W-1:0]  AMP_MAX    = {1'b0, {(AMP_W-1){1'b1}}};

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W:0]   sum;
    logic               wrap_now;
    logic               wrap_q;
    logic               fire_q;
    wave_t              wave_q;
    logic [DUTY_W-1:0]  duty_q;
    logic [2:0]         vol_q;
    logic               noise;

    // Carry out of the accumulator is the natural wrap; sync always wraps.
    assign sum      = {1'b0, phase_q} + {1'b0, incr_in};
    assign wrap_now = sync_in | (step_in & sum[PHASE_W]);

    osc_lfsr u_lfsr (
        .clk     (clk_in),
        .rst     (rst_in),
        .advance (wrap_now),
        .seed    (LFSR_SEED),
        .noise   (noise)
    );

    logic [AMP_W-1:0]        t_bits;
    logic [AMP_W-1:0]        u_bits;
    logic [AMP_W-1:0]        tri_bits;
    logic                    pulse_hi;
    logic [AMP_W-1:0]        shaped;
    logic signed [AMP_W-1:0] amp_next;

    always_comb begin
        t_bits   = phase_q[PHASE_W-1 -: AMP_W];
        u_bits   = phase_q[PHASE_W-2 -: AMP_W];
        // Fold the second half of the cycle, then offset by flipping the MSB
        // (subtracting 2^(AMP_W-1) modulo 2^AMP_W).
        tri_bits = (phase_q[PHASE_W-1] ? ~u_bits : u_bits) ^ AMP_MIN;
        pulse_hi = phase_q[PHASE_W-1 -: DUTY_W] < duty_q;
        shaped   = t_bits;
        case (wave_q)
            WAVE_SAW:   shaped = t_bits;
            WAVE_TRI:   shaped = tri_bits;
            WAVE_PULSE: shaped = pulse_hi ? AMP_MAX : AMP_MIN;
            WAVE_NOISE: shaped = noise ? AMP_MAX : AMP_MIN;
            default:    shaped = t_bits;
        endcase
        amp_next = $signed(shaped) >>> vol_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            fire_q    <= 1'b0;
            wave_q    <= WAVE_SAW;
            duty_q    <= DUTY_RESET;
            vol_q     <= VOL_RESET;
            amp_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            fire_q <= step_in | sync_in;
            wrap_q <= wrap_now;
            if (sync_in) begin
                phase_q <= '0;
            end else if (step_in) begin
                phase_q <= sum[PHASE_W-1:0];
            end
            // Settings only land at a wrap so a cycle never changes shape mid-way.
            if (wrap_now) begin
                wave_q <= wave_t'(wave_in);
                duty_q <= duty_in;
                vol_q  <= vol_in;
            end
            valid_out <= fire_q;
            if (fire_q) begin
                amp_out <= amp_next;
            end
        end
    end

    assign wrap_out = wrap_q;

endmodule
